// File: rtl/multi_port_register_file_pkg.sv
// Shared register-file types: data/address widths, write-port bundle, port-count defaults.
// Latency: n/a (types only).
// Backpressure: n/a.
package BasicTypes;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [XLEN-1:0]   BasicData;
    typedef logic [ADDR_W-1:0] RegAddr;
endpackage

package RegisterFileTypes;
    import BasicTypes::*;

    localparam int DEFAULT_NUM_READ  = 2;
    localparam int DEFAULT_NUM_WRITE = 1;

    typedef struct packed {
        logic     we;
        RegAddr   addr;
        BasicData data;
    } WritePort;
endpackage

// File: rtl/multi_port_register_file_if.sv
// Bundle between DecodeStage, the WriteBackStage lanes and the register file.
// Latency: n/a (wires only).
// Backpressure: none; decode stalls itself on rdReady/busyVec.
interface RegisterFileIF
    import BasicTypes::*;
    import RegisterFileTypes::*;
#(
    parameter int NUM_READ  = DEFAULT_NUM_READ,
    parameter int NUM_WRITE = DEFAULT_NUM_WRITE
);
    RegAddr               rdAddr  [NUM_READ];
    BasicData             rdData  [NUM_READ];
    logic                 rdReady [NUM_READ];
    WritePort             wPort   [NUM_WRITE];
    logic                 issueEnable;
    RegAddr               issueAddr;
    logic                 flush;
    logic [NUM_REGS-1:0]  busyVec;

    modport DecodeStage (
        output rdAddr, issueEnable, issueAddr, flush,
        input  rdData, rdReady, busyVec
    );
    // Each lane drives its own wPort entry.
    modport WriteBackStage (
        output wPort
    );
    modport RegisterFile (
        input  rdAddr, wPort, issueEnable, issueAddr, flush,
        output rdData, rdReady, busyVec
    );
endinterface

// File: rtl/multi_port_register_file_register_scoreboard.sv
// Pending-write scoreboard: flush > issue set > write-back clear > hold; x0 never busy.
// Latency: busyVec updates one edge after issue/clear/flush.
// Backpressure: none; WAW hazards are decode's responsibility.
module register_scoreboard
#(
    parameter int NUM_REGS  = 32,
    parameter int NUM_WRITE = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issueEnable,
    input  logic [ADDR_W-1:0]   issueAddr,
    input  logic                flush,
    input  logic                wEnable [NUM_WRITE],
    input  logic [ADDR_W-1:0]   wAddr   [NUM_WRITE],
    output logic [NUM_REGS-1:0] busyVec
);
    logic [NUM_REGS-1:1] busy;
    logic [NUM_REGS-1:1] clear;

    always_comb begin
        clear = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wEnable[w] && (wAddr[w] == ADDR_W'(r))) begin
                    clear[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (flush) begin
                    busy[r] <= 1'b0;
                end else if (issueEnable && (issueAddr == ADDR_W'(r))) begin
                    busy[r] <= 1'b1;
                end else if (clear[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign busyVec = {busy, 1'b0};
endmodule

// File: rtl/multi_port_register_file.sv
// Multi-port register file with x0 hardwired, same-cycle write forwarding and pending-write scoreboard.
// Latency: reads combinational, writes visible from flops one edge later (forwarded in the strobe cycle).
// Backpressure: none; rdReady tells decode whether an operand is valid.
module multi_port_register_file
    import BasicTypes::*;
    import RegisterFileTypes::*;
#(
    parameter int XLEN      = BasicTypes::XLEN,
    parameter int NUM_REGS  = BasicTypes::NUM_REGS,
    parameter int NUM_READ  = DEFAULT_NUM_READ,
    parameter int NUM_WRITE = DEFAULT_NUM_WRITE,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rdAddr  [NUM_READ],
    output logic [XLEN-1:0]     rdData  [NUM_READ],
    output logic                rdReady [NUM_READ],
    input  logic                wEnable [NUM_WRITE],
    input  logic [ADDR_W-1:0]   wAddr   [NUM_WRITE],
    input  logic [XLEN-1:0]     wData   [NUM_WRITE],
    input  logic                issueEnable,
    input  logic [ADDR_W-1:0]   issueAddr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busyVec
);
    logic [XLEN-1:0] regs [NUM_REGS-1:1];

    // Later lanes overwrite earlier ones in loop order, so the highest lane wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wEnable[w] && (wAddr[w] != '0)) begin
                    regs[wAddr[w]] <= wData[w];
                end
            end
        end
    end

    register_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issueEnable (issueEnable),
        .issueAddr   (issueAddr),
        .flush       (flush),
        .wEnable     (wEnable),
        .wAddr       (wAddr),
        .busyVec     (busyVec)
    );

    // Forwarding is gated by rst so reset reads are clean zeros regardless of lane activity.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            logic fwdHit;
            fwdHit     = 1'b0;
            rdData[i]  = '0;
            rdReady[i] = 1'b1;
            if (rst && (rdAddr[i] != '0)) begin
                rdData[i] = regs[rdAddr[i]];
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wEnable[w] && (wAddr[w] == rdAddr[i])) begin
                        rdData[i] = wData[w];
                        fwdHit    = 1'b1;
                    end
                end
                rdReady[i] = !busyVec[rdAddr[i]] || fwdHit;
            end
        end
    end
endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench for multi_port_register_file with two write lanes.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_multi_port_register_file;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW = 5;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     rdAddr  [NRD];
    logic [XLEN-1:0]   rdData  [NRD];
    logic              rdReady [NRD];
    logic              wEnable [NWR];
    logic [AW-1:0]     wAddr   [NWR];
    logic [XLEN-1:0]   wData   [NWR];
    logic              issueEnable;
    logic [AW-1:0]     issueAddr;
    logic              flush;
    logic [NREGS-1:0]  busyVec;

    int checks = 0;
    int errors = 0;

    multi_port_register_file #(
        .XLEN      (XLEN),
        .NUM_REGS  (NREGS),
        .NUM_READ  (NRD),
        .NUM_WRITE (NWR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdAddr      (rdAddr),
        .rdData      (rdData),
        .rdReady     (rdReady),
        .wEnable     (wEnable),
        .wAddr       (wAddr),
        .wData       (wData),
        .issueEnable (issueEnable),
        .issueAddr   (issueAddr),
        .flush       (flush),
        .busyVec     (busyVec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int w = 0; w < NWR; w++) begin
            wEnable[w] = 1'b0;
            wAddr[w]   = '0;
            wData[w]   = '0;
        end
        issueEnable = 1'b0;
        issueAddr   = '0;
        flush       = 1'b0;
    endtask

    task automatic wr(input int lane, input int addr, input logic [XLEN-1:0] val);
        wEnable[lane] = 1'b1;
        wAddr[lane]   = AW'(addr);
        wData[lane]   = val;
    endtask

    task automatic issue(input int addr);
        issueEnable = 1'b1;
        issueAddr   = AW'(addr);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rdAddr[0] = 5'd5;
        rdAddr[1] = 5'd0;

        // In reset: writes and forwarding suppressed.
        #2;
        wr(0, 5, 32'hAA);
        issue(6);
        #1;
        chk("rst_fwd_off", 64'(rdData[0]), 64'h0);
        chk("rst_ready", 64'(rdReady[0]), 64'h1);
        @(posedge clk); #1;
        chk("rst_busy", 64'(busyVec), 64'h0);
        chk("rst_write_ignored", 64'(rdData[0]), 64'h0);

        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        chk("reset_rd0", 64'(rdData[0]), 64'h0);
        chk("reset_rd1", 64'(rdData[1]), 64'h0);
        chk("reset_rdy0", 64'(rdReady[0]), 64'h1);
        chk("reset_rdy1", 64'(rdReady[1]), 64'h1);
        chk("reset_busy", 64'(busyVec), 64'h0);

        // Write x5 with same-cycle forward, then from flops.
        @(negedge clk);
        wr(0, 5, 32'hDEADBEEF);
        #1;
        chk("fwd_x5", 64'(rdData[0]), 64'hDEADBEEF);
        @(negedge clk);
        idle();
        #1;
        chk("stored_x5", 64'(rdData[0]), 64'hDEADBEEF);

        // x0 stays zero.
        @(negedge clk);
        rdAddr[1] = 5'd0;
        wr(0, 0, 32'h1234);
        #1;
        chk("x0_fwd", 64'(rdData[1]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("x0_stored", 64'(rdData[1]), 64'h0);
        chk("x0_no_busy", 64'(busyVec), 64'h0);

        // Lane conflict: highest lane wins.
        @(negedge clk);
        rdAddr[1] = 5'd7;
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        #1;
        chk("conflict_fwd", 64'(rdData[1]), 64'h22);
        @(negedge clk);
        idle();
        #1;
        chk("conflict_stored", 64'(rdData[1]), 64'h22);

        // Scoreboard set / clear.
        @(negedge clk);
        rdAddr[0] = 5'd3;
        issue(3);
        #1;
        chk("issue_pre_ready", 64'(rdReady[0]), 64'h1);
        @(negedge clk);
        idle();
        #1;
        chk("issue_busy", 64'(busyVec), 64'h8);
        chk("issue_not_ready", 64'(rdReady[0]), 64'h0);
        chk("busy_other_ready", 64'(rdReady[1]), 64'h1);
        @(negedge clk);
        wr(0, 3, 32'h55);
        #1;
        chk("wb_ready", 64'(rdReady[0]), 64'h1);
        chk("wb_fwd", 64'(rdData[0]), 64'h55);
        @(negedge clk);
        idle();
        #1;
        chk("wb_cleared", 64'(busyVec), 64'h0);
        chk("wb_ready_after", 64'(rdReady[0]), 64'h1);

        // Set wins over same-cycle clear.
        @(negedge clk);
        issue(3);
        wr(1, 3, 32'h66);
        #1;
        chk("setclr_ready", 64'(rdReady[0]), 64'h1);
        @(negedge clk);
        idle();
        #1;
        chk("setclr_busy", 64'(busyVec), 64'h8);
        chk("setclr_data", 64'(rdData[0]), 64'h66);
        chk("setclr_not_ready", 64'(rdReady[0]), 64'h0);

        // Issue to x0 ignored; mark x1, x2, x9.
        @(negedge clk); issue(0);
        @(negedge clk); issue(1);
        @(negedge clk); issue(2);
        @(negedge clk); issue(9);
        @(negedge clk);
        idle();
        #1;
        chk("marked_busy", 64'(busyVec), 64'h20E);

        // Flush overrides issue, write still commits.
        @(negedge clk);
        flush = 1'b1;
        issue(4);
        wr(0, 9, 32'h9);
        rdAddr[1] = 5'd9;
        @(negedge clk);
        idle();
        #1;
        chk("flush_busy", 64'(busyVec), 64'h0);
        chk("flush_x9", 64'(rdData[1]), 64'h9);

        // Async reset between edges.
        @(negedge clk);
        rdAddr[0] = 5'd5;
        rdAddr[1] = 5'd7;
        issue(5);
        @(negedge clk);
        idle();
        #1;
        chk("pre_arst_busy", 64'(busyVec), 64'h20);
        chk("pre_arst_x7", 64'(rdData[1]), 64'h22);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_x5", 64'(rdData[0]), 64'h0);
        chk("arst_x7", 64'(rdData[1]), 64'h0);
        chk("arst_busy", 64'(busyVec), 64'h0);
        chk("arst_ready", 64'(rdReady[0]), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("post_arst_x7", 64'(rdData[1]), 64'h0);
        chk("post_arst_busy", 64'(busyVec), 64'h0);

        // First edge after reset performs normal updates.
        @(negedge clk);
        wr(0, 5, 32'h77);
        issue(7);
        @(negedge clk);
        idle();
        #1;
        chk("post_arst_write", 64'(rdData[0]), 64'h77);
        chk("post_arst_issue", 64'(busyVec), 64'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
